// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store sequencer to a word-wide data memory
// Turns byte/half/word requests into one or two aligned word cycles with lane enables.
module lsu_mem_ctrl #(
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wd,
   output logic [3:0]  o_mem_wen,
   output logic        o_mem_ren,
   input  logic [31:0] i_mem_rd
);

   typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

   state_t      state, state_nx;
   logic        we_q, err_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, buf0, buf1;
   logic [31:0] mem_addr_q, mem_wd_q;

   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
      if (f3[1:0] == 2'b11) return 1'b0;
      if (we) return !f3[2];
      return !(f3[2] && f3[1]);
   endfunction

   // Decision on the incoming request, made in the accept cycle
   logic [3:0] req_m;
   logic       req_bad;
   assign req_m   = size_mask(i_req_funct3[1:0]);
   assign req_bad = !funct3_ok(i_req_we, i_req_funct3) ||
                    (!ALLOW_MISALIGN && (|(req_m >> (3'd4 - {1'b0, i_req_addr[1:0]}))));

   logic [1:0]  off;
   logic [5:0]  sh;
   logic [3:0]  m, mask0, mask1;
   logic        split;
   logic [31:0] wd0, wd1, wa0, wa1, r32, ld;

   assign off   = addr_q[1:0];
   assign sh    = {off, 3'b000};
   assign m     = size_mask(f3_q[1:0]);
   assign mask0 = m << off;
   assign mask1 = m >> (3'd4 - {1'b0, off});
   assign split = |mask1;
   assign wd0   = wdata_q << sh;
   assign wd1   = wdata_q >> (6'd32 - sh);
   assign wa0   = {addr_q[31:2], 2'b00};
   assign wa1   = wa0 + 32'd4;
   // Lower word supplies the low bytes, upper word fills in above; a shift of 32 yields 0
   assign r32   = (buf0 >> sh) | (buf1 << (6'd32 - sh));

   always_comb begin
      ld = r32;
      case (f3_q)
         3'b000:  ld = {{24{r32[7]}}, r32[7:0]};
         3'b001:  ld = {{16{r32[15]}}, r32[15:0]};
         3'b100:  ld = {24'b0, r32[7:0]};
         3'b101:  ld = {16'b0, r32[15:0]};
         default: ld = r32;
      endcase
   end

   always_comb begin
      state_nx   = state;
      o_mem_addr = mem_addr_q;
      o_mem_wd   = mem_wd_q;
      o_mem_wen  = 4'b0000;
      o_mem_ren  = 1'b0;
      case (state)
         IDLE:  if (i_req_valid) state_nx = req_bad ? RESP : ACC0;
         ACC0: begin
            o_mem_addr = wa0;
            if (we_q) begin
               o_mem_wen = mask0;
               o_mem_wd  = wd0;
               state_nx  = split ? ACC1 : RESP;
            end else begin
               o_mem_ren = 1'b1;
               state_nx  = WAIT0;
            end
         end
         WAIT0: state_nx = split ? ACC1 : RESP;
         ACC1: begin
            o_mem_addr = wa1;
            if (we_q) begin
               o_mem_wen = mask1;
               o_mem_wd  = wd1;
               state_nx  = RESP;
            end else begin
               o_mem_ren = 1'b1;
               state_nx  = WAIT1;
            end
         end
         WAIT1:   state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign o_req_ready = (state == IDLE);
   assign o_rsp_valid = (state == RESP);
   assign o_rsp_err   = (state == RESP) && err_q;
   assign o_rsp_rdata = ((state == RESP) && !we_q && !err_q) ? ld : 32'h0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         buf0       <= 32'h0;
         buf1       <= 32'h0;
         mem_addr_q <= 32'h0;
         mem_wd_q   <= 32'h0;
      end else begin
         state      <= state_nx;
         mem_addr_q <= o_mem_addr;
         mem_wd_q   <= o_mem_wd;
         if (state == IDLE && i_req_valid) begin
            we_q    <= i_req_we;
            f3_q    <= i_req_funct3;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            err_q   <= req_bad;
         end
         if (state == WAIT0) buf0 <= i_mem_rd;
         if (state == WAIT1) buf1 <= i_mem_rd;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
// Byte-addressed reference memory predicts load data; a word memory model serves the DUT.
module tb_lsu_mem_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, va, vb, req_we;
   logic [2:0]  req_f3;
   logic [31:0] req_addr, req_wdata;

   logic        ready, rsp_valid, rsp_err, mem_ren;
   logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
   logic [3:0]  mem_wen;

   logic        nm_ready, nm_rsp_valid, nm_rsp_err, nm_mem_ren;
   logic [31:0] nm_rsp_rdata, nm_mem_addr, nm_mem_wd;
   logic [3:0]  nm_mem_wen;

   lsu_mem_ctrl #(.ALLOW_MISALIGN(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(va), .o_req_ready(ready),
      .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_wen(mem_wen), .o_mem_ren(mem_ren),
      .i_mem_rd(mem_rd)
   );

   lsu_mem_ctrl #(.ALLOW_MISALIGN(1'b0)) dut_nm (
      .i_clk(clk), .i_rst(rst), .i_req_valid(vb), .o_req_ready(nm_ready),
      .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(nm_rsp_valid), .o_rsp_rdata(nm_rsp_rdata), .o_rsp_err(nm_rsp_err),
      .o_mem_addr(nm_mem_addr), .o_mem_wd(nm_mem_wd), .o_mem_wen(nm_mem_wen), .o_mem_ren(nm_mem_ren),
      .i_mem_rd(32'h0)
   );

   // Word memory seen by the DUT (64 words, aliased on addr[7:2])
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (mem_ren) mem_rd <= mem[mem_addr[7:2]];
      for (int i = 0; i < 4; i++)
         if (mem_wen[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wd[8*i +: 8];
   end

   int checks = 0;
   int errors = 0;
   int nm_strobes = 0;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wd;
      logic        ren;
   } strobe_t;
   strobe_t slog[$];

   always @(negedge clk) begin
      if (mem_ren || mem_wen != 4'b0000) begin
         slog.push_back('{mem_addr, mem_wen, mem_wd, mem_ren});
         checks++;
         if ((mem_ren && mem_wen != 4'b0000) || mem_addr[1:0] != 2'b00) begin
            errors++;
            $display("FAIL strobe_legal actual addr=%h wen=%b ren=%b required aligned, ren/wen exclusive",
                     mem_addr, mem_wen, mem_ren);
         end
      end
      if (nm_mem_ren || nm_mem_wen != 4'b0000) begin
         nm_strobes++;
         checks++;
         if (nm_mem_addr[1:0] != 2'b00) begin
            errors++;
            $display("FAIL nm_strobe_align actual=%h required low bits 00", nm_mem_addr);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: flat byte memory and the ISA rules
   logic [7:0] ref_mem [256];

   function automatic int fsize(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit is_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 <= 3'd2;
      return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v = 32'h0;
      int n = fsize(f3);
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(addr[7:0] + i)];
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      chk(sel ? "nm_ready" : "ready", {31'b0, sel ? nm_ready : ready}, 32'h1);
      req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
      if (sel) vb = 1'b1; else va = 1'b1;
      @(posedge clk);
      #1;
      va = 1'b0; vb = 1'b0;
      lat = -1; rdata = 32'hxxxx_xxxx; err = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (sel ? nm_rsp_valid : rsp_valid) begin
            lat = n;
            rdata = sel ? nm_rsp_rdata : rsp_rdata;
            err = sel ? nm_rsp_err : rsp_err;
            break;
         end
      end
      if (!sel && we && is_legal(we, f3))
         for (int i = 0; i < fsize(f3); i++) ref_mem[8'(addr[7:0] + i)] = wdata[8*i +: 8];
   endtask

   task automatic chk_strobe(input string nm, input int idx, input logic [31:0] a,
                             input logic [3:0] w, input logic [31:0] d);
      if (idx >= slog.size()) begin
         checks++; errors++;
         $display("FAIL %s_present actual count=%0d required>%0d", nm, slog.size(), idx);
         return;
      end
      chk({nm, "_addr"}, slog[idx].addr, a);
      chk({nm, "_wen"}, {28'b0, slog[idx].wen}, {28'b0, w});
      chk({nm, "_wd"}, slog[idx].wd, d);
      chk({nm, "_ren"}, {31'b0, slog[idx].ren}, 32'h0);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } vec_t;
   vec_t vt[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a, d, exp_rd;
      logic        er, w;
      logic [2:0]  f;
      int          lat, n, exp_lat, exp_acc;
      bit          lg, sp, seen;

      rst = 1'b1; va = 1'b0; vb = 1'b0;
      req_we = 1'b0; req_f3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'h1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      chk("rst_mem_wen", {28'b0, mem_wen}, 32'h0);
      chk("rst_mem_ren", {31'b0, mem_ren}, 32'h0);

      // Aligned SW and SB lane placement
      slog.delete();
      do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk("sw10_lat", lat, 2); chk("sw10_err", {31'b0, er}, 32'h0); chk("sw10_n", slog.size(), 1);
      chk_strobe("sw10", 0, 32'h10, 4'b1111, 32'hDEADBEEF);
      slog.delete();
      do_req(1'b0, 1'b1, 3'b000, 32'h22, 32'h000000AB, rd, er, lat);
      chk("sb22_lat", lat, 2); chk("sb22_n", slog.size(), 1);
      chk_strobe("sb22", 0, 32'h20, 4'b0100, 32'h00AB0000);

      vt.push_back('{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b1, 3'b010, 32'h24, 32'h55667788, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b001, 32'h23, 32'h0, 32'hFFFF8811, 1'b0, 5, 2});
      vt.push_back('{1'b0, 3'b101, 32'h23, 32'h0, 32'h00008811, 1'b0, 5, 2});
      vt.push_back('{1'b1, 3'b000, 32'h22, 32'hAB, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b0, 3'b100, 32'h22, 32'h0, 32'h000000AB, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFAB, 1'b0, 3, 1});
      vt.push_back('{1'b1, 3'b000, 32'h22, 32'h80, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b100, 32'h22, 32'h0, 32'h00000080, 1'b0, 3, 1});
      vt.push_back('{1'b1, 3'b010, 32'h21, 32'h00AABBCC, 32'h0, 1'b0, 3, 2});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'hAABBCC44, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b010, 32'h24, 32'h0, 32'h55667700, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b010, 32'h21, 32'h0, 32'h00AABBCC, 1'b0, 5, 2});
      vt.push_back('{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFAABB, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0});
      vt.push_back('{1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0});
      vt.push_back('{1'b0, 3'b110, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0});
      vt.push_back('{1'b1, 3'b101, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0});
      vt.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'hAABBCC44, 1'b0, 3, 1});
      vt.push_back('{1'b1, 3'b001, 32'h26, 32'h1234, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b0, 3'b101, 32'h26, 32'h0, 32'h00001234, 1'b0, 3, 1});
      vt.push_back('{1'b1, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 2, 1});
      vt.push_back('{1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0, 1'b0, 3, 2});
      vt.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'hF00D0000, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b010, 32'h0, 32'h0, 32'h0000CAFE, 1'b0, 3, 1});
      vt.push_back('{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFFEF0, 1'b0, 5, 2});

      foreach (vt[i]) begin
         slog.delete();
         do_req(1'b0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
         chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].err});
         chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("vec%0d_acc", i), slog.size(), vt[i].acc);
      end

      // Split store lanes, and word-address wrap on the second half
      slog.delete();
      do_req(1'b0, 1'b1, 3'b010, 32'h21, 32'h00AABBCC, rd, er, lat);
      chk_strobe("split0", 0, 32'h20, 4'b1110, 32'hAABBCC00);
      chk_strobe("split1", 1, 32'h24, 4'b0001, 32'h00000000);
      slog.delete();
      do_req(1'b0, 1'b1, 3'b010, 32'hFFFFFFFE, 32'h12345678, rd, er, lat);
      chk_strobe("wrap0", 0, 32'hFFFFFFFC, 4'b1100, 32'h56780000);
      chk_strobe("wrap1", 1, 32'h00000000, 4'b0011, 32'h00001234);

      // Reset during WAIT0 of a split LW
      slog.delete();
      @(negedge clk);
      req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h22; va = 1'b1;
      @(posedge clk); #1 va = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_ready", {31'b0, ready}, 32'h1);
      chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("mid_rsp_rdata", rsp_rdata, 32'h0);
      chk("mid_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("mid_mem_addr", mem_addr, 32'h0);
      chk("mid_mem_wd", mem_wd, 32'h0);
      chk("mid_mem_wen", {28'b0, mem_wen}, 32'h0);
      chk("mid_mem_ren", {31'b0, mem_ren}, 32'h0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("mid_no_rsp", {31'b0, seen}, 32'h0);
      chk("mid_one_access", slog.size(), 1);
      do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      chk("post_rst_rdata", rd, ref_load(3'b010, 32'h20));
      chk("post_rst_lat", lat, 3);

      // Misalignment rejected when splitting is disabled
      n = nm_strobes;
      do_req(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, rd, er, lat);
      chk("nm_err", {31'b0, er}, 32'h1); chk("nm_lat", lat, 1); chk("nm_rdata", rd, 32'h0);
      chk("nm_no_access", nm_strobes - n, 0);
      do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      chk("nm_al_err", {31'b0, er}, 32'h0); chk("nm_al_lat", lat, 3);
      chk("nm_al_access", nm_strobes - n, 1);

      // Randomized traffic against the byte-level model
      for (int k = 0; k < 64; k++) begin
         a = $urandom;
         do_req(1'b0, 1'b1, 3'b010, {a[31:8], 6'(k), 2'b00}, $urandom, rd, er, lat);
      end
      for (int k = 0; k < 300; k++) begin
         w = 1'($urandom_range(0, 1));
         f = 3'($urandom_range(0, 7));
         a = $urandom; d = $urandom;
         lg = is_legal(w, f);
         n = fsize(f);
         sp = (int'(a[1:0]) + n) > 4;
         exp_rd = (!w && lg) ? ref_load(f, a) : 32'h0;
         exp_lat = !lg ? 1 : (w ? (sp ? 3 : 2) : (sp ? 5 : 3));
         exp_acc = !lg ? 0 : (sp ? 2 : 1);
         slog.delete();
         do_req(1'b0, w, f, a, d, rd, er, lat);
         chk($sformatf("rnd%0d_rdata", k), rd, exp_rd);
         chk($sformatf("rnd%0d_err", k), {31'b0, er}, {31'b0, !lg});
         chk($sformatf("rnd%0d_lat", k), lat, exp_lat);
         chk($sformatf("rnd%0d_acc", k), slog.size(), exp_acc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
